// File: rtl/reg_file_dump.sv
// reg_file_dump: stalls the core, walks a register range through one
// register-file read port and streams each value out with its index.
module reg_file_dump #(
   parameter int unsigned FIRST_REG    = 0,
   parameter int unsigned LAST_REG     = 31,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        start_i,
   output logic        dbg_stall_o,
   output logic [4:0]  rf_addr_o,
   input  logic [31:0] rf_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_data_o,
   output logic [4:0]  out_index_o,
   output logic        out_last_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [4:0] FIRST = 5'(FIRST_REG);
   localparam logic [4:0] LAST  = 5'(LAST_REG);
   localparam logic [3:0] DRAIN = 4'(DRAIN_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      DRAIN_S,
      READ,
      SEND,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] data_q, data_d;
   logic [4:0]  index_q, index_d;
   logic        last_q, last_d;
   logic        valid_q, busy_q, stall_q, done_q;

   // Next-state and capture logic for the dump sequence
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      index_d = index_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               idx_d   = FIRST;
               cnt_d   = DRAIN;
               state_d = (DRAIN == 4'd0) ? READ : DRAIN_S;
            end
         end
         DRAIN_S: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = READ;
            end
         end
         READ: begin
            data_d  = rf_data_i;
            index_d = idx_q;
            last_d  = (idx_q == LAST);
            state_d = SEND;
         end
         SEND: begin
            if (out_ready_i) begin
               if (idx_q == LAST) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = READ;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, captured beat and registered state decodes
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         idx_q   <= 5'd0;
         cnt_q   <= 4'd0;
         data_q  <= 32'd0;
         index_q <= 5'd0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         stall_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         index_q <= index_d;
         last_q  <= last_d;
         valid_q <= (state_d == SEND);
         busy_q  <= (state_d != IDLE);
         stall_q <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
      end
   end

   assign rf_addr_o   = idx_q;
   assign dbg_stall_o = stall_q;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign out_index_o = index_q;
   assign out_last_o  = last_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule
